tile_pixel_renderer: RTL

- Sits between the SD tile loader and the TFT SPI serializer inside the audio/video peripheral.
- Holds two on-chip memories, both filled by the SD read path through byte-wide write ports:
  - a tile pixel store: 32 tiles of 8x8 pixels, RGB332, one byte per pixel;
  - a tile map: 20x16 entries, 5-bit tile index each.
- On a frame-start request it walks the 160x128 screen in raster order.
- For each pixel it emits one RGB565 word to the TFT serializer over a valid/ready handshake.

---
 rtl/audvid_pkg.sv | 32 +++
 rtl/sync_dpram.sv | 41 ++++
 rtl/tile_pixel_renderer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/audvid_pkg.sv
// Shared definitions for the audio/video peripheral tile renderer:
// screen geometry, memory address widths, FSM states and colour expansion.
package audvid_pkg;

    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 128;
    localparam int TILE_SIZE   = 8;

    localparam int TILE_ADDR_W = 11;  // {tile[4:0], y[2:0], x[2:0]}
    localparam int MAP_ADDR_W  = 9;   // row*TILE_COLS+col
    localparam int TILE_IDX_W  = 5;   // tile index stored in the map

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAP_RD,
        ST_PIX_RD,
        ST_PIX_OUT,
        ST_DONE
    } render_state_t;

    // RGB332 -> RGB565 by bit replication, so full-scale maps to full-scale.
    function automatic logic [15:0] rgb332_to_rgb565(input logic [7:0] px);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = px[7:5];
        g = px[4:2];
        b = px[1:0];
        return {r, r[2:1], g, g, b, b, b[1]};
    endfunction

endpackage

// File: rtl/sync_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
// Writes beyond DEPTH are dropped. The read register clears on rst so the
// consumer sees a defined word after reset; the array itself is never cleared.
module sync_dpram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    // Store the incoming word when the address lies inside the array.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; only updates when rd_en so the word is held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tile_pixel_renderer.sv
// Tile-map pixel renderer: walks the screen in raster order, looks up the
// tile index for each pixel, fetches the RGB332 texel and hands an RGB565
// word to the TFT serializer over a valid/ready handshake.
module tile_pixel_renderer
    import audvid_pkg::*;
#(
    parameter int TILE_COLS = 20,
    parameter int TILE_ROWS = 16,
    parameter int NUM_TILES = 32
) (
    input  logic        MasterCLK,
    input  logic        Reset,
    input  logic        TileWrEn,
    input  logic [10:0] TileWrAddr,
    input  logic [7:0]  TileWrData,
    input  logic        MapWrEn,
    input  logic [8:0]  MapWrAddr,
    input  logic [4:0]  MapWrData,
    input  logic        FrameStart,
    output logic [15:0] PixelData,
    output logic        PixelValid,
    input  logic        PixelReady,
    output logic        Busy,
    output logic        FrameDone
);

    localparam int LAST_X     = TILE_COLS * TILE_SIZE - 1;
    localparam int LAST_Y     = TILE_ROWS * TILE_SIZE - 1;
    localparam int X_W        = $clog2(TILE_COLS * TILE_SIZE);
    localparam int Y_W        = $clog2(TILE_ROWS * TILE_SIZE);
    localparam int MAP_DEPTH  = TILE_COLS * TILE_ROWS;
    localparam int TILE_DEPTH = NUM_TILES * TILE_SIZE * TILE_SIZE;

    render_state_t             state;
    render_state_t             state_nxt;
    logic [X_W-1:0]            px_x;
    logic [Y_W-1:0]            px_y;
    logic [MAP_ADDR_W-1:0]     map_rd_addr;
    logic [TILE_IDX_W-1:0]     map_q;
    logic [TILE_ADDR_W-1:0]    pix_rd_addr;
    logic [7:0]                pix_q;
    logic                      handshake;
    logic                      last_x;
    logic                      last_px;

    assign map_rd_addr = MAP_ADDR_W'(px_y >> 3) * MAP_ADDR_W'(TILE_COLS)
                       + MAP_ADDR_W'(px_x >> 3);
    assign pix_rd_addr = {map_q, px_y[2:0], px_x[2:0]};

    assign handshake = PixelValid && PixelReady;
    assign last_x    = (px_x == X_W'(LAST_X));
    assign last_px   = last_x && (px_y == Y_W'(LAST_Y));

    // The texel register only reloads in PIX_RD, so it doubles as the
    // held output word during backpressure; expansion is pure wiring.
    assign PixelData = rgb332_to_rgb565(pix_q);

    sync_dpram #(
        .DATA_W (TILE_IDX_W),
        .DEPTH  (MAP_DEPTH),
        .ADDR_W (MAP_ADDR_W)
    ) u_map (
        .clk     (MasterCLK),
        .rst     (Reset),
        .wr_en   (MapWrEn),
        .wr_addr (MapWrAddr),
        .wr_data (MapWrData),
        .rd_en   (state == ST_MAP_RD),
        .rd_addr (map_rd_addr),
        .rd_data (map_q)
    );

    sync_dpram #(
        .DATA_W (8),
        .DEPTH  (TILE_DEPTH),
        .ADDR_W (TILE_ADDR_W)
    ) u_tiles (
        .clk     (MasterCLK),
        .rst     (Reset),
        .wr_en   (TileWrEn),
        .wr_addr (TileWrAddr),
        .wr_data (TileWrData),
        .rd_en   (state == ST_PIX_RD),
        .rd_addr (pix_rd_addr),
        .rd_data (pix_q)
    );

    // FSM state register.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one cycle per memory lookup, then wait for the handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (FrameStart) state_nxt = ST_MAP_RD;
            ST_MAP_RD:  state_nxt = ST_PIX_RD;
            ST_PIX_RD:  state_nxt = ST_PIX_OUT;
            ST_PIX_OUT: if (handshake) state_nxt = last_px ? ST_DONE : ST_MAP_RD;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Raster position, handshake valid flag and frame status outputs.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            px_x       <= '0;
            px_y       <= '0;
            PixelValid <= 1'b0;
            Busy       <= 1'b0;
            FrameDone  <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (FrameStart) begin
                        Busy <= 1'b1;
                        px_x <= '0;
                        px_y <= '0;
                    end
                end
                ST_PIX_RD: begin
                    PixelValid <= 1'b1;
                end
                ST_PIX_OUT: begin
                    if (handshake) begin
                        PixelValid <= 1'b0;
                        if (last_x) begin
                            px_x <= '0;
                            px_y <= px_y + 1'b1;
                        end else begin
                            px_x <= px_x + 1'b1;
                        end
                        if (last_px) begin
                            Busy      <= 1'b0;
                            FrameDone <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
